// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register file write port between ALU (A) and load (M) paths.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding of the registered write to the read ports.
module regfile_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int STALL_CW     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [4:0]          a_rd,
    input  logic [XLEN-1:0]     a_data,
    input  logic                m_valid,
    output logic                m_ready,
    input  logic [4:0]          m_rd,
    input  logic [XLEN-1:0]     m_data,
    output logic                RegWrite,
    output logic [4:0]          WriteReg,
    output logic [XLEN-1:0]     WriteData,
    output logic                m_boost,
    output logic [STALL_CW-1:0] stall_cnt
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]          rs1_addr,
    input  logic [4:0]          rs2_addr,
    input  logic [XLEN-1:0]     rf_data1,
    input  logic [XLEN-1:0]     rf_data2,
    output logic [XLEN-1:0]     fwd_data1,
    output logic [XLEN-1:0]     fwd_data2
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0]     starveQ;
    logic              aWins;
    logic              mWins;
    logic              accept;
    logic [4:0]        winRd;
    logic [XLEN-1:0]   winData;
    logic              stallNow;

    assign m_boost = (starveQ == STARVE_MAX);

    // A normally wins; a saturated starvation count flips priority to M
    assign aWins = a_valid && !(m_boost && m_valid);
    assign mWins = m_valid && !aWins;

    assign a_ready  = !reset && aWins;
    assign m_ready  = !reset && mWins;
    assign accept   = a_ready || m_ready;
    assign winRd    = a_ready ? a_rd : m_rd;
    assign winData  = a_ready ? a_data : m_data;
    assign stallNow = (a_valid && !a_ready) || (m_valid && !m_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (accept) begin
            RegWrite  <= (winRd != 5'd0);
            WriteReg  <= winRd;
            WriteData <= winData;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starveQ <= '0;
        end else if (m_valid && !m_ready) begin
            if (starveQ != STARVE_MAX) begin
                starveQ <= starveQ + 1'b1;
            end
        end else begin
            starveQ <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stallNow && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Register file write lands at the edge, so a same-cycle read would see stale data
    assign fwd_data1 = (RegWrite && (WriteReg == rs1_addr) && (rs1_addr != 5'd0)) ? WriteData : rf_data1;
    assign fwd_data2 = (RegWrite && (WriteReg == rs2_addr) && (rs2_addr != 5'd0)) ? WriteData : rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps plus a randomized phase against a behavioural model.
// Define WB_BYPASS_EN to also exercise the forwarding outputs.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;
    localparam int LIMIT = 4;
    localparam int SCW = 4;
    localparam int STALL_MAX = (1 << SCW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            aValid, mValid;
    logic            aReady, mReady;
    logic [4:0]      aRd, mRd;
    logic [XLEN-1:0] aData, mData;
    logic            regWrite;
    logic [4:0]      writeReg;
    logic [XLEN-1:0] writeData;
    logic            mBoost;
    logic [SCW-1:0]  stallCnt;
`ifdef WB_BYPASS_EN
    logic [4:0]      rs1Addr = '0, rs2Addr = '0;
    logic [XLEN-1:0] rfData1 = '0, rfData2 = '0;
    logic [XLEN-1:0] fwdData1, fwdData2;
`endif

    int tests = 0;
    int failures = 0;

    // Model of the architectural behaviour: state after the most recent edge
    logic            mdlRegWrite;
    logic [4:0]      mdlWriteReg;
    logic [XLEN-1:0] mdlWriteData;
    int              mdlStarve;
    int              mdlStall;
    logic            lastAccA, lastAccM;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .STALL_CW(SCW)) dut (
        .clk(clk), .reset(reset),
        .a_valid(aValid), .a_ready(aReady), .a_rd(aRd), .a_data(aData),
        .m_valid(mValid), .m_ready(mReady), .m_rd(mRd), .m_data(mData),
        .RegWrite(regWrite), .WriteReg(writeReg), .WriteData(writeData),
        .m_boost(mBoost), .stall_cnt(stallCnt)
`ifdef WB_BYPASS_EN
        , .rs1_addr(rs1Addr), .rs2_addr(rs2Addr), .rf_data1(rfData1), .rf_data2(rfData2),
        .fwd_data1(fwdData1), .fwd_data2(fwdData2)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle, compares at the negedge, then advances the model across the posedge
    task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] ard, input logic [63:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [63:0] md);
        logic boost, expA, expM;
        reset = rst; aValid = av; aRd = ard; aData = ad;
        mValid = mv; mRd = mrd; mData = md;
        @(negedge clk);
        boost = (mdlStarve >= LIMIT);
        expA = !rst && av && (!boost || !mv);
        expM = !rst && mv && !expA;
        checkOutput("a_ready", aReady, expA);
        checkOutput("m_ready", mReady, expM);
        checkOutput("RegWrite", regWrite, mdlRegWrite);
        checkOutput("WriteReg", writeReg, mdlWriteReg);
        checkOutput("WriteData", writeData, mdlWriteData);
        checkOutput("m_boost", mBoost, boost);
        checkOutput("stall_cnt", stallCnt, mdlStall);
        @(posedge clk);
        #1;
        lastAccA = expA;
        lastAccM = expM;
        if (rst) begin
            mdlRegWrite = 0; mdlWriteReg = 0; mdlWriteData = 0; mdlStarve = 0; mdlStall = 0;
        end else begin
            if (expA || expM) begin
                mdlWriteReg  = expA ? ard : mrd;
                mdlWriteData = expA ? ad : md;
                mdlRegWrite  = (mdlWriteReg != 0);
            end else begin
                mdlRegWrite = 0;
            end
            if ((av && !expA) || (mv && !expM)) mdlStall = (mdlStall + 1 > STALL_MAX) ? STALL_MAX : mdlStall + 1;
            if (mv && !expM) mdlStarve = (mdlStarve + 1 > LIMIT) ? LIMIT : mdlStarve + 1;
            else mdlStarve = 0;
        end
    endtask

    initial begin
        logic av, mv;
        logic [4:0] ard, mrd;
        logic [63:0] ad, md;

        reset = 1; aValid = 0; mValid = 0; aRd = 0; mRd = 0; aData = 0; mData = 0;
        repeat (2) @(posedge clk);
        #1;
        mdlRegWrite = 0; mdlWriteReg = 0; mdlWriteData = 0; mdlStarve = 0; mdlStall = 0;
        lastAccA = 0; lastAccM = 0;

        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 5, 64'hDEAD_BEEF, 0, 0, 0);
        checkOutput("awrite_we", regWrite, 1);
        checkOutput("awrite_reg", writeReg, 5);
        checkOutput("awrite_data", writeData, 64'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("awrite_we_drop", regWrite, 0);

        // Starvation: reset first so stall_cnt starts from zero
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 9, 64'h11 + i, 1, 12, 64'h4444);
        checkOutput("boost_set", mBoost, 1);
        applyStimulus(0, 1, 9, 64'h15, 1, 12, 64'h4444);
        checkOutput("boost_clear", mBoost, 0);
        checkOutput("starve_stall", stallCnt, 5);
        checkOutput("starve_wreg", writeReg, 12);

        applyStimulus(0, 0, 0, 0, 1, 0, 64'h1);
        checkOutput("x0_we", regWrite, 0);

        for (int i = 0; i < (1 << SCW) + 3; i++) applyStimulus(0, 1, 3, 64'h33, 1, 4, 64'h44);
        checkOutput("stall_sat", stallCnt, STALL_MAX);

        applyStimulus(0, 1, 7, 64'h7777, 0, 0, 0);
        applyStimulus(1, 1, 8, 64'h8888, 1, 9, 64'h9999);
        checkOutput("rst_we", regWrite, 0);
        checkOutput("rst_wreg", writeReg, 0);
        checkOutput("rst_stall", stallCnt, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

`ifdef WB_BYPASS_EN
        applyStimulus(0, 1, 3, 64'hABCD, 0, 0, 0);
        rs1Addr = 3; rs2Addr = 0; rfData1 = 64'h1111; rfData2 = 64'h2222;
        #1;
        checkOutput("fwd1", fwdData1, 64'hABCD);
        checkOutput("fwd2", fwdData2, 64'h2222);
        rs1Addr = 0;
`endif

        av = 0; mv = 0; ard = 0; mrd = 0; ad = 0; md = 0;
        for (int i = 0; i < 300; i++) begin
            if (!av || lastAccA) begin
                av = 1'($urandom_range(0, 1)); ard = 5'($urandom_range(0, 31)); ad = {$urandom, $urandom};
            end
            if (!mv || lastAccM) begin
                mv = 1'($urandom_range(0, 1)); mrd = 5'($urandom_range(0, 31)); md = {$urandom, $urandom};
            end
            applyStimulus($urandom_range(0, 59) == 0, av, ard, ad, mv, mrd, md);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
